// File: rtl/pwm_sequencer.sv
// pwm_sequencer: steps through a small table of PWM profiles, drives the
// configuration inputs of a pwm generator and clears it at every profile boundary.
module pwm_sequencer #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [15:0]   cfg_period,
    input  logic [7:0]    cfg_duty,
    input  logic          cfg_burst,
    input  logic          cfg_type,
    input  logic [7:0]    cfg_reps,
    input  logic [AW:0]   num_steps,
    input  logic          loop,
    input  logic          start,
    input  logic          abort,
    output logic [15:0]   period,
    output logic [7:0]    dutyCycle,
    output logic          modeBurst,
    output logic          typeBurst,
    output logic          pwm_clr,
    output logic          busy,
    output logic [AW-1:0] step,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    // Profile table
    logic [15:0] tbl_period_q [DEPTH];
    logic [15:0] tbl_period_d [DEPTH];
    logic [7:0]  tbl_duty_q   [DEPTH];
    logic [7:0]  tbl_duty_d   [DEPTH];
    logic        tbl_burst_q  [DEPTH];
    logic        tbl_burst_d  [DEPTH];
    logic        tbl_type_q   [DEPTH];
    logic        tbl_type_d   [DEPTH];
    logic [7:0]  tbl_reps_q   [DEPTH];
    logic [7:0]  tbl_reps_d   [DEPTH];

    // Sequencer state
    state_t      state_q, state_d;
    logic [15:0] period_q, period_d;
    logic [7:0]  duty_q, duty_d;
    logic        burst_q, burst_d;
    logic        type_q, type_d;
    logic [7:0]  reps_q, reps_d;
    logic [15:0] pcnt_q, pcnt_d;
    logic [7:0]  rcnt_q, rcnt_d;
    logic [AW:0] nsteps_q, nsteps_d;
    logic [AW-1:0] step_q, step_d;
    logic        clr_q, clr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [15:0]   p_eff;
    logic [7:0]    r_eff;
    logic [AW:0]   nsteps_clamp;
    logic          load;
    logic [AW-1:0] load_idx;

    // Table write port: one entry per cycle, accepted in any state
    always_comb begin
        tbl_period_d = tbl_period_q;
        tbl_duty_d   = tbl_duty_q;
        tbl_burst_d  = tbl_burst_q;
        tbl_type_d   = tbl_type_q;
        tbl_reps_d   = tbl_reps_q;
        if (cfg_we) begin
            tbl_period_d[cfg_addr] = cfg_period;
            tbl_duty_d[cfg_addr]   = cfg_duty;
            tbl_burst_d[cfg_addr]  = cfg_burst;
            tbl_type_d[cfg_addr]   = cfg_type;
            tbl_reps_d[cfg_addr]   = cfg_reps;
        end
    end

    // Table registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tbl_period_q[i] <= '0;
                tbl_duty_q[i]   <= '0;
                tbl_burst_q[i]  <= 1'b0;
                tbl_type_q[i]   <= 1'b0;
                tbl_reps_q[i]   <= '0;
            end
        end else begin
            tbl_period_q <= tbl_period_d;
            tbl_duty_q   <= tbl_duty_d;
            tbl_burst_q  <= tbl_burst_d;
            tbl_type_q   <= tbl_type_d;
            tbl_reps_q   <= tbl_reps_d;
        end
    end

    // Zero period/reps behave as 1; step count saturates at the table depth
    always_comb begin
        p_eff        = (period_q == '0) ? 16'd1 : period_q;
        r_eff        = (reps_q == '0) ? 8'd1 : reps_q;
        nsteps_clamp = (num_steps > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_steps;
    end

    // Next-state logic: table stepping, period/repeat counting, abort handling
    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        duty_d   = duty_q;
        burst_d  = burst_q;
        type_d   = type_q;
        reps_d   = reps_q;
        pcnt_d   = pcnt_q;
        rcnt_d   = rcnt_q;
        nsteps_d = nsteps_q;
        step_d   = step_q;
        done_d   = 1'b0;
        load     = 1'b0;
        load_idx = '0;

        case (state_q)
            S_IDLE: begin
                if (start && (num_steps != '0)) begin
                    nsteps_d = nsteps_clamp;
                    load     = 1'b1;
                    load_idx = '0;
                end
            end
            S_LOAD: begin
                pcnt_d  = '0;
                rcnt_d  = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (pcnt_q == p_eff - 16'd1) begin
                    pcnt_d = '0;
                    if (rcnt_q + 8'd1 == r_eff) begin
                        if ({1'b0, step_q} != nsteps_q - (AW+1)'(1)) begin
                            load     = 1'b1;
                            load_idx = step_q + AW'(1);
                        end else if (loop) begin
                            load     = 1'b1;
                            load_idx = '0;
                        end else begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        rcnt_d = rcnt_q + 8'd1;
                    end
                end else begin
                    pcnt_d = pcnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything, including a start in the same cycle
        if (abort) begin
            load   = 1'b0;
            done_d = 1'b0;
            if (state_q != S_IDLE) state_d = S_IDLE;
        end

        // Profile outputs are captured only when entering LOAD
        if (load) begin
            state_d  = S_LOAD;
            step_d   = load_idx;
            period_d = tbl_period_q[load_idx];
            duty_d   = tbl_duty_q[load_idx];
            burst_d  = tbl_burst_q[load_idx];
            type_d   = tbl_type_q[load_idx];
            reps_d   = tbl_reps_q[load_idx];
            pcnt_d   = '0;
            rcnt_d   = '0;
        end

        // Status outputs are decoded from the next state so they are registered
        clr_d  = (state_d != S_RUN);
        busy_d = (state_d != S_IDLE);
    end

    // Sequencer registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            period_q <= '0;
            duty_q   <= '0;
            burst_q  <= 1'b0;
            type_q   <= 1'b0;
            reps_q   <= '0;
            pcnt_q   <= '0;
            rcnt_q   <= '0;
            nsteps_q <= '0;
            step_q   <= '0;
            clr_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            duty_q   <= duty_d;
            burst_q  <= burst_d;
            type_q   <= type_d;
            reps_q   <= reps_d;
            pcnt_q   <= pcnt_d;
            rcnt_q   <= rcnt_d;
            nsteps_q <= nsteps_d;
            step_q   <= step_d;
            clr_q    <= clr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign period    = period_q;
    assign dutyCycle = duty_q;
    assign modeBurst = burst_q;
    assign typeBurst = type_q;
    assign pwm_clr   = clr_q;
    assign busy      = busy_q;
    assign step      = step_q;
    assign done      = done_q;

endmodule
